i2c_xfer_seq: RTL and testbench

Transaction sequencer that sits on top of the I2C master byte controller and turns one host request into a complete register-oriented I2C transfer: START, device address, register address, then N data bytes written or read (repeated START for reads), then STOP. It owns the byte controller's command inputs (start/stop/read/write/ack_in/din). It checks slave ACKs, handles arbitration loss, and streams write/read data to and from the host side.

---
 rtl/i2c_xfer_seq.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_i2c_xfer_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_xfer_seq.sv
// Register-oriented I2C transfer sequencer: turns one host request into
// START, device address, register address, N data bytes and STOP on the byte controller.
module i2c_xfer_seq #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rnw,
    input  logic [6:0]       req_dev,
    input  logic [7:0]       req_reg,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [7:0]       wdata,
    output logic             rdata_valid,
    output logic [7:0]       rdata,
    output logic             done,
    output logic             st_nack,
    output logic             st_al,
    output logic             st_err,
    output logic             busy,
    output logic             bc_start,
    output logic             bc_stop,
    output logic             bc_read,
    output logic             bc_write,
    output logic             bc_ack_in,
    output logic [7:0]       bc_din,
    input  logic             bc_cmd_ack,
    input  logic             bc_ack_out,
    input  logic             bc_al,
    input  logic [7:0]       bc_dout
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ADDR   = 4'd1,
        ST_REG    = 4'd2,
        ST_WFETCH = 4'd3,
        ST_WDATA  = 4'd4,
        ST_RSTART = 4'd5,
        ST_RDATA  = 4'd6,
        ST_STOP   = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       read;
        logic       write;
        logic       ack_in;
        logic [7:0] din;
    } cmd_t;

    localparam cmd_t CMD_NONE = '0;

    function automatic cmd_t mk_cmd(input logic c_start, input logic c_stop, input logic c_read,
                                    input logic c_write, input logic c_ack_in,
                                    input logic [7:0] c_din);
        cmd_t c;
        c.start  = c_start;
        c.stop   = c_stop;
        c.read   = c_read;
        c.write  = c_write;
        c.ack_in = c_ack_in;
        c.din    = c_din;
        return c;
    endfunction

    state_t           state_r, state_nxt_s, nack_state_s;
    cmd_t             cmd_r, cmd_nxt_s, nack_cmd_s;
    logic [6:0]       dev_r, dev_nxt_s;
    logic [7:0]       reg_r, reg_nxt_s;
    logic [LEN_W-1:0] len_r, len_nxt_s, cnt_r, cnt_nxt_s;
    logic [LEN_W-1:0] len_m1_s, cnt_inc_s;
    logic             rnw_r, rnw_nxt_s;
    logic             nack_r, nack_nxt_s, al_r, al_nxt_s, err_r, err_nxt_s;
    logic             last_s, last_nx_s, al_hit_s;
    logic             done_r, busy_r, req_ready_r, rdata_valid_r;
    logic [7:0]       rdata_r;

    assign len_m1_s  = len_r - LEN_W'(1);
    assign cnt_inc_s = (cnt_r == '1) ? cnt_r : cnt_r + LEN_W'(1);
    assign last_s    = (cnt_r == len_m1_s);
    assign last_nx_s = (cnt_inc_s == len_m1_s);
    assign al_hit_s  = bc_al && (state_r != ST_IDLE) && (state_r != ST_DONE);

    // A refused byte that already carried STOP has ended the bus transfer itself
    assign nack_state_s = cmd_r.stop ? ST_DONE : ST_STOP;
    assign nack_cmd_s   = cmd_r.stop ? CMD_NONE : mk_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Next-state, next-command and status decode
    always_comb begin
        state_nxt_s = state_r;
        cmd_nxt_s   = cmd_r;
        dev_nxt_s   = dev_r;
        reg_nxt_s   = reg_r;
        len_nxt_s   = len_r;
        rnw_nxt_s   = rnw_r;
        cnt_nxt_s   = cnt_r;
        nack_nxt_s  = nack_r;
        al_nxt_s    = al_r;
        err_nxt_s   = err_r;
        if (al_hit_s) begin
            state_nxt_s = ST_DONE;
            cmd_nxt_s   = CMD_NONE;
            al_nxt_s    = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        dev_nxt_s  = req_dev;
                        reg_nxt_s  = req_reg;
                        len_nxt_s  = req_len;
                        rnw_nxt_s  = req_rnw;
                        cnt_nxt_s  = '0;
                        nack_nxt_s = 1'b0;
                        al_nxt_s   = 1'b0;
                        if (req_rnw && (req_len == '0)) begin
                            state_nxt_s = ST_DONE;
                            err_nxt_s   = 1'b1;
                        end else begin
                            state_nxt_s = ST_ADDR;
                            err_nxt_s   = 1'b0;
                            cmd_nxt_s   = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {req_dev, 1'b0});
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (bc_cmd_ack && bc_ack_out) begin
                        nack_nxt_s  = 1'b1;
                        state_nxt_s = nack_state_s;
                        cmd_nxt_s   = nack_cmd_s;
                    end else if (bc_cmd_ack) begin
                        state_nxt_s = ST_REG;
                        cmd_nxt_s   = mk_cmd(1'b0, !rnw_r && (len_r == '0), 1'b0, 1'b1, 1'b0, reg_r);
                    end else begin
                        state_nxt_s = ST_ADDR;
                    end
                end
                ST_REG: begin
                    if (bc_cmd_ack && bc_ack_out) begin
                        nack_nxt_s  = 1'b1;
                        state_nxt_s = nack_state_s;
                        cmd_nxt_s   = nack_cmd_s;
                    end else if (bc_cmd_ack && rnw_r) begin
                        state_nxt_s = ST_RSTART;
                        cmd_nxt_s   = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {dev_r, 1'b1});
                    end else if (bc_cmd_ack) begin
                        state_nxt_s = cmd_r.stop ? ST_DONE : ST_WFETCH;
                        cmd_nxt_s   = CMD_NONE;
                    end else begin
                        state_nxt_s = ST_REG;
                    end
                end
                ST_WFETCH: begin
                    if (wdata_valid) begin
                        state_nxt_s = ST_WDATA;
                        cmd_nxt_s   = mk_cmd(1'b0, last_s, 1'b0, 1'b1, 1'b0, wdata);
                    end else begin
                        state_nxt_s = ST_WFETCH;
                    end
                end
                ST_WDATA: begin
                    if (bc_cmd_ack) begin
                        cnt_nxt_s = cnt_inc_s;
                        if (bc_ack_out) begin
                            nack_nxt_s  = 1'b1;
                            state_nxt_s = nack_state_s;
                            cmd_nxt_s   = nack_cmd_s;
                        end else begin
                            state_nxt_s = cmd_r.stop ? ST_DONE : ST_WFETCH;
                            cmd_nxt_s   = CMD_NONE;
                        end
                    end else begin
                        state_nxt_s = ST_WDATA;
                    end
                end
                ST_RSTART: begin
                    if (bc_cmd_ack && bc_ack_out) begin
                        nack_nxt_s  = 1'b1;
                        state_nxt_s = nack_state_s;
                        cmd_nxt_s   = nack_cmd_s;
                    end else if (bc_cmd_ack) begin
                        state_nxt_s = ST_RDATA;
                        cmd_nxt_s   = mk_cmd(1'b0, last_s, 1'b1, 1'b0, last_s, 8'h00);
                    end else begin
                        state_nxt_s = ST_RSTART;
                    end
                end
                ST_RDATA: begin
                    // The final read carries STOP, so it doubles as the last-byte marker
                    if (bc_cmd_ack && cmd_r.stop) begin
                        cnt_nxt_s   = cnt_inc_s;
                        state_nxt_s = ST_DONE;
                        cmd_nxt_s   = CMD_NONE;
                    end else if (bc_cmd_ack) begin
                        cnt_nxt_s   = cnt_inc_s;
                        state_nxt_s = ST_RDATA;
                        cmd_nxt_s   = mk_cmd(1'b0, last_nx_s, 1'b1, 1'b0, last_nx_s, 8'h00);
                    end else begin
                        state_nxt_s = ST_RDATA;
                    end
                end
                ST_STOP: begin
                    if (bc_cmd_ack) begin
                        state_nxt_s = ST_DONE;
                        cmd_nxt_s   = CMD_NONE;
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cmd_nxt_s   = CMD_NONE;
                end
            endcase
        end
    end

    // State, command, request context, status and host-side output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cmd_r         <= CMD_NONE;
            dev_r         <= 7'd0;
            reg_r         <= 8'd0;
            len_r         <= '0;
            rnw_r         <= 1'b0;
            cnt_r         <= '0;
            nack_r        <= 1'b0;
            al_r          <= 1'b0;
            err_r         <= 1'b0;
            done_r        <= 1'b0;
            busy_r        <= 1'b0;
            req_ready_r   <= 1'b1;
            rdata_valid_r <= 1'b0;
            rdata_r       <= 8'd0;
        end else begin
            state_r       <= state_nxt_s;
            cmd_r         <= cmd_nxt_s;
            dev_r         <= dev_nxt_s;
            reg_r         <= reg_nxt_s;
            len_r         <= len_nxt_s;
            rnw_r         <= rnw_nxt_s;
            cnt_r         <= cnt_nxt_s;
            nack_r        <= nack_nxt_s;
            al_r          <= al_nxt_s;
            err_r         <= err_nxt_s;
            done_r        <= (state_nxt_s == ST_DONE);
            busy_r        <= (state_nxt_s != ST_IDLE);
            req_ready_r   <= (state_nxt_s == ST_IDLE);
            rdata_valid_r <= (state_r == ST_RDATA) && bc_cmd_ack && !bc_al;
            if ((state_r == ST_RDATA) && bc_cmd_ack && !bc_al) begin
                rdata_r <= bc_dout;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign req_ready   = req_ready_r;
    assign wdata_ready = (state_r == ST_WFETCH);
    assign rdata_valid = rdata_valid_r;
    assign rdata       = rdata_r;
    assign done        = done_r;
    assign busy        = busy_r;
    assign st_nack     = nack_r;
    assign st_al       = al_r;
    assign st_err      = err_r;
    assign bc_start    = cmd_r.start;
    assign bc_stop     = cmd_r.stop;
    assign bc_read     = cmd_r.read;
    assign bc_write    = cmd_r.write;
    assign bc_ack_in   = cmd_r.ack_in;
    assign bc_din      = cmd_r.din;

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Scoreboard bench for i2c_xfer_seq: a byte-controller responder, a write-data source,
// and a monitor that checks acked commands, read strobes and done status against queues.
module tb_i2c_xfer_seq;

    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid, req_ready, req_rnw;
    logic [6:0]       req_dev;
    logic [7:0]       req_reg;
    logic [LEN_W-1:0] req_len;
    logic             wdata_valid, wdata_ready;
    logic [7:0]       wdata;
    logic             rdata_valid;
    logic [7:0]       rdata;
    logic             done, st_nack, st_al, st_err, busy;
    logic             bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
    logic [7:0]       bc_din;
    logic             bc_cmd_ack, bc_ack_out, bc_al;
    logic [7:0]       bc_dout;

    i2c_xfer_seq #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata),
        .done(done), .st_nack(st_nack), .st_al(st_al), .st_err(st_err), .busy(busy),
        .bc_start(bc_start), .bc_stop(bc_stop), .bc_read(bc_read), .bc_write(bc_write),
        .bc_ack_in(bc_ack_in), .bc_din(bc_din),
        .bc_cmd_ack(bc_cmd_ack), .bc_ack_out(bc_ack_out), .bc_al(bc_al), .bc_dout(bc_dout)
    );

    always #5 clk = ~clk;

    logic [12:0] exp_cmd[$];
    logic [7:0]  exp_rd[$];
    logic [2:0]  exp_done[$];
    logic [8:0]  resp_q[$];
    logic [7:0]  wq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wcnt  = 0;
    logic        wd_hold = 1'b0;
    logic        hs_pend = 1'b0;

    function automatic logic [12:0] cmd(input logic s, input logic p, input logic r,
                                        input logic w, input logic a, input logic [7:0] d);
        return {s, p, r, w, a, d};
    endfunction

    function automatic logic [28:0] all_outs();
        return {req_ready, wdata_ready, rdata_valid, done, st_nack, st_al, st_err, busy,
                bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din, rdata};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Byte-controller responder: acks each command after a fixed delay
    initial begin
        bc_cmd_ack = 1'b0; bc_ack_out = 1'b0; bc_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (rst || bc_cmd_ack) begin
                bc_cmd_ack = 1'b0;
                wcnt = 0;
            end else if (bc_start || bc_stop || bc_read || bc_write) begin
                if (wcnt == 2) begin
                    bc_cmd_ack = 1'b1;
                    wcnt = 0;
                    if (resp_q.size() > 0) {bc_ack_out, bc_dout} = resp_q.pop_front();
                    else begin bc_ack_out = 1'b0; bc_dout = 8'h00; end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Write-data source
    initial begin
        wdata_valid = 1'b0; wdata = 8'h00;
        forever begin
            @(negedge clk);
            if (hs_pend && wq.size() > 0) void'(wq.pop_front());
            if (!wd_hold && wq.size() > 0) begin
                wdata_valid = 1'b1; wdata = wq[0];
            end else begin
                wdata_valid = 1'b0; wdata = 8'h00;
            end
            hs_pend = wdata_valid && wdata_ready && !rst;
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                if (bc_cmd_ack) begin
                    if (exp_cmd.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL bc_cmd_unexpected: got 0x%0h expected none",
                                 {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din});
                    end else begin
                        chk("bc_cmd", 32'({bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din}),
                            32'(exp_cmd.pop_front()));
                    end
                end
                if (rdata_valid) begin
                    if (exp_rd.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL rdata_unexpected: got 0x%0h expected none", rdata);
                    end else begin
                        chk("rdata", 32'(rdata), 32'(exp_rd.pop_front()));
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL done_unexpected: got 1 expected 0");
                    end else begin
                        chk("done_status", 32'({st_nack, st_al, st_err}), 32'(exp_done.pop_front()));
                    end
                end
            end
        end
    end

    task automatic issue(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [LEN_W-1:0] len);
        int n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        chk("req_ready_before_issue", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_rnw = rnw; req_dev = dev; req_reg = rg; req_len = len;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 500) begin @(negedge clk); n++; end
        chk({name, "_done_seen"}, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        req_valid = 1'b0; req_rnw = 1'b0; req_dev = 7'd0; req_reg = 8'd0; req_len = '0;
        bc_al = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(all_outs()), 32'({1'b1, 28'd0}));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", 32'(all_outs()), 32'({1'b1, 28'd0}));

        // Two-byte write
        exp_cmd.push_back(cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA0));
        exp_cmd.push_back(cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10));
        exp_cmd.push_back(cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5));
        exp_cmd.push_back(cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C));
        exp_done.push_back(3'b000);
        for (int i = 0; i < 4; i++) resp_q.push_back(9'h000);
        wq.push_back(8'hA5); wq.push_back(8'h3C);
        issue(1'b0, 7'h50, 8'h10, 4'd2);
        chk("req_ready_low_after_accept", 32'(req_ready), 32'd0);
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_done("write2");
        chk("req_ready_after_done", 32'(req_ready), 32'd1);

        // Three-byte read
        exp_cmd.push_back(cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA0));
        exp_cmd.push_back(cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02));
        exp_cmd.push_back(cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA1));
        exp_cmd.push_back(cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
        exp_cmd.push_back(cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
        exp_cmd.push_back(cmd(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00));
        exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
        exp_done.push_back(3'b000);
        for (int i = 0; i < 3; i++) resp_q.push_back(9'h000);
        resp_q.push_back(9'h011); resp_q.push_back(9'h022); resp_q.push_back(9'h033);
        issue(1'b1, 7'h50, 8'h02, 4'd3);
        wait_done("read3");

        // Address NACK on a write: lone STOP, no register byte
        exp_cmd.push_back(cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h74));
        exp_cmd.push_back(cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
        exp_done.push_back(3'b100);
        resp_q.push_back(9'h100); resp_q.push_back(9'h000);
        issue(1'b0, 7'h3A, 8'h10, 4'd1);
        wait_done("addr_nack");

        // Arbitration loss during the register byte of a read
        exp_cmd.push_back(cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA0));
        exp_done.push_back(3'b010);
        resp_q.push_back(9'h000);
        issue(1'b1, 7'h50, 8'h02, 4'd2);
        n = 0;
        while (!(bc_write && !bc_start && bc_din == 8'h02) && n < 200) begin @(negedge clk); n++; end
        chk("al_reg_phase_seen", 32'(bc_write && !bc_start && bc_din == 8'h02), 32'd1);
        bc_al = 1'b1;
        @(negedge clk);
        bc_al = 1'b0;
        chk("al_cmds_cleared", 32'({bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din}), 32'd0);
        chk("al_done", 32'(done), 32'd1);
        chk("al_status", 32'({st_nack, st_al, st_err}), 32'(3'b010));
        @(negedge clk);
        chk("al_req_ready", 32'(req_ready), 32'd1);

        // Zero-length read: error without bus activity
        exp_done.push_back(3'b001);
        issue(1'b1, 7'h50, 8'h02, 4'd0);
        chk("rlen0_done", 32'(done), 32'd1);
        chk("rlen0_err", 32'(st_err), 32'd1);
        chk("rlen0_no_cmd", 32'({bc_start, bc_stop, bc_read, bc_write}), 32'd0);
        @(negedge clk);

        // Zero-length write: STOP rides on the register byte
        exp_cmd.push_back(cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA0));
        exp_cmd.push_back(cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77));
        exp_done.push_back(3'b000);
        resp_q.push_back(9'h000); resp_q.push_back(9'h000);
        issue(1'b0, 7'h50, 8'h77, 4'd0);
        wait_done("wlen0");

        // Reset in the middle of a data byte after a stalled fetch
        exp_cmd.push_back(cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h56));
        exp_cmd.push_back(cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h07));
        resp_q.push_back(9'h000); resp_q.push_back(9'h000);
        wd_hold = 1'b1;
        wq.push_back(8'hC3); wq.push_back(8'hD4);
        issue(1'b0, 7'h2B, 8'h07, 4'd2);
        n = 0;
        while (!wdata_ready && n < 200) begin @(negedge clk); n++; end
        chk("wfetch_reached", 32'(wdata_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("wfetch_bus_idle", 32'({bc_start, bc_stop, bc_read, bc_write}), 32'd0);
        wd_hold = 1'b0;
        n = 0;
        while (!(bc_write && bc_din == 8'hC3) && n < 200) begin @(negedge clk); n++; end
        chk("wdata_phase_seen", 32'(bc_write && bc_din == 8'hC3), 32'd1);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", 32'(all_outs()), 32'({1'b1, 28'd0}));
        wq.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Clean request after reset
        exp_cmd.push_back(cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h46));
        exp_cmd.push_back(cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h45));
        exp_cmd.push_back(cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h99));
        exp_done.push_back(3'b000);
        for (int i = 0; i < 3; i++) resp_q.push_back(9'h000);
        wq.push_back(8'h99);
        issue(1'b0, 7'h23, 8'h45, 4'd1);
        wait_done("post_reset_write");
        repeat (3) @(negedge clk);

        chk("exp_cmd_drained", 32'(exp_cmd.size()), 32'd0);
        chk("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
        chk("exp_done_drained", 32'(exp_done.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
